// File: rtl/instr_fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues 1-cycle-latency word reads to
// instruction memory and queues returned {pc, instr} pairs for decode.
module instr_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic [31:0]     i_imem_rdata,
    output logic            o_id_valid,
    output logic [31:0]     o_id_instr,
    output logic [XLEN-1:0] o_id_pc,
    input  logic            i_id_ready,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_full
);

    localparam int              PW       = $clog2(DEPTH);
    localparam int              CW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
    localparam logic [CW:0]     CREDITS  = (CW + 1)'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic            inflight;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            full_q;
    entry_t          mem [DEPTH];

    logic            issue;
    logic            push;
    logic            pop;
    logic [CW:0]     credits_used;

    // A slot is reserved at issue time, so a returning word always has room.
    assign credits_used = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign issue        = i_reset && !i_redirect && (credits_used < CREDITS);
    assign push         = inflight && !i_redirect;
    assign pop          = (count != '0) && i_id_ready && !i_redirect;

    assign o_imem_req  = issue;
    assign o_imem_addr = fetch_pc;
    assign o_id_valid  = (count != '0);
    assign o_id_instr  = o_id_valid ? mem[rd_ptr].instr : '0;
    assign o_id_pc     = o_id_valid ? mem[rd_ptr].pc    : '0;
    assign o_full      = full_q;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full_q   <= 1'b0;
        end else if (i_redirect) begin
            // Masking keeps every redirect bit in use while forcing word alignment.
            fetch_pc <= i_redirect_pc & ~XLEN'(3);
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full_q   <= 1'b0;
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + XLEN'(4);
                req_pc   <= fetch_pc;
            end
            inflight <= issue;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count    <= count_next;
            full_q   <= (count_next == FULL_CNT);
        end
    end

    // NOTE: queue storage is not reset; count gates every read, so stale contents are never visible.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= '{pc: req_pc, instr: i_imem_rdata};
    end

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_reset)
        !(push && count == FULL_CNT))
        else $error("push into full fetch queue");

endmodule
